// File: rtl/lc_scan_scheduler.sv
// lc_scan_scheduler: scan-side link-controller scheduler.
// Turns page-scan / inquiry-scan enable and cancel oneshots plus the
// interval/window slot registers into mutually exclusive scan windows.
// It yields to an active connection and hands over to RESP on an
// access-code hit.
// Optional build macro: SCAN_INTERLACE_EN. When defined, a window whose
// interlace request is set at window start runs for twice its length.
module lc_scan_scheduler #(
   parameter int SLOT_CLKS = 3750,
   parameter int CNT_W     = 16
) (
   input  logic             clk_6M,
   input  logic             rstz,
   input  logic             regi_PageScanEnable_oneshot,
   input  logic             regi_PageScanCancel_oneshot,
   input  logic             regi_InquiryScanEnable_oneshot,
   input  logic             regi_InquiryScanCancel_oneshot,
   input  logic [CNT_W-1:0] regi_Tpsinterval,
   input  logic [CNT_W-1:0] regi_Tpswindow,
   input  logic [CNT_W-1:0] regi_Tisinterval,
   input  logic [CNT_W-1:0] regi_Tiswindow,
   input  logic             regi_psinterlace,
   input  logic             regi_isinterlace,
   input  logic             conn_busy,
   input  logic             rx_hit_p,
   input  logic             resp_done_p,
   output logic             slot_p,
   output logic             pagescan_en,
   output logic             inquiryscan_en,
   output logic             ps_start_p,
   output logic             is_start_p,
   output logic             scan_resp_p,
   output logic             resp_is_inquiry,
   output logic             interlace_phase,
   output logic [1:0]       scan_state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PS_WIN = 2'd1,
      ST_IS_WIN = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   localparam int PS      = 0;
   localparam int IS      = 1;
   localparam int CW      = CNT_W + 1;   // window count holds up to 2x window
   localparam int PRESC_W = (SLOT_CLKS > 1) ? $clog2(SLOT_CLKS) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SLOT_CLKS - 1);

   state_t            state_reg, state_next;
   logic [PRESC_W-1:0] presc_reg;
   logic              slot_tick;
   logic [CW-1:0]     win_cnt_reg, win_cnt_next;
   logic              resp_inq_reg, resp_inq_next;
   logic              ps_start_reg, is_start_reg, resp_p_reg;
   logic              resp_enter;
   logic [1:0]        en_p, cancel_p, scan_pend, win_start;
   logic              ps_go, is_go, active_cancel, win_end, ilace_act;
   logic [CW-1:0]     ps_win_base, is_win_base, win_base, win_total, win_last;

   // Free-running slot prescaler; slot_p marks the last clock of each slot
   always_ff @(posedge clk_6M) begin
      if (!rstz)
         presc_reg <= '0;
      else if (presc_reg == PRESC_LAST)
         presc_reg <= '0;
      else
         presc_reg <= presc_reg + 1'b1;
   end

   assign slot_tick = (presc_reg == PRESC_LAST);
   assign slot_p    = slot_tick;

   assign en_p     = {regi_InquiryScanEnable_oneshot, regi_PageScanEnable_oneshot};
   assign cancel_p = {regi_InquiryScanCancel_oneshot, regi_PageScanCancel_oneshot};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_scan
         logic             flag_reg;
         logic             pend_reg;
         logic [CNT_W-1:0] ivl_cnt_reg;
         logic [CNT_W-1:0] ivl_sel;
         logic [CNT_W-1:0] ivl_last;
         logic             expire;

         assign ivl_sel  = (gi == PS) ? regi_Tpsinterval : regi_Tisinterval;
         // interval 0 behaves like interval 1
         assign ivl_last = (ivl_sel == '0) ? '0 : ivl_sel - 1'b1;
         assign expire   = flag_reg & slot_tick & (ivl_cnt_reg >= ivl_last);

         // Enable flag, interval counter and single-bit pending request.
         // A fresh expiry outranks the clear from a window start, so
         // back-to-back windows keep flowing when window >= interval.
         always_ff @(posedge clk_6M) begin
            if (!rstz) begin
               flag_reg    <= 1'b0;
               pend_reg    <= 1'b0;
               ivl_cnt_reg <= '0;
            end else if (cancel_p[gi]) begin
               flag_reg <= 1'b0;
               pend_reg <= 1'b0;
            end else if (en_p[gi] && !flag_reg) begin
               flag_reg    <= 1'b1;
               pend_reg    <= 1'b1;
               ivl_cnt_reg <= '0;
            end else begin
               if (flag_reg && slot_tick)
                  ivl_cnt_reg <= expire ? '0 : ivl_cnt_reg + 1'b1;
               if (expire)
                  pend_reg <= 1'b1;
               else if (win_start[gi])
                  pend_reg <= 1'b0;
            end
         end

         assign scan_pend[gi] = pend_reg;
      end
   endgenerate

   // a window may only be granted to a request that is not being cancelled
   assign ps_go = scan_pend[PS] & ~cancel_p[PS] & ~conn_busy;
   assign is_go = scan_pend[IS] & ~cancel_p[IS] & ~conn_busy;
   assign active_cancel = (state_reg == ST_PS_WIN) ? cancel_p[PS] : cancel_p[IS];

   // window 0 behaves like window 1; interlace doubles the length
   assign ps_win_base = (regi_Tpswindow == '0) ? CW'(1) : {1'b0, regi_Tpswindow};
   assign is_win_base = (regi_Tiswindow == '0) ? CW'(1) : {1'b0, regi_Tiswindow};
   assign win_base    = (state_reg == ST_IS_WIN) ? is_win_base : ps_win_base;
   assign win_total   = ilace_act ? {win_base[CW-2:0], 1'b0} : win_base;
   assign win_last    = win_total - 1'b1;
   assign win_end     = (win_cnt_reg >= win_last);

   // Next-state logic: slot-boundary arbitration plus any-cycle cancel/hit/done
   always_comb begin
      state_next    = state_reg;
      win_cnt_next  = win_cnt_reg;
      win_start     = 2'b00;
      resp_enter    = 1'b0;
      resp_inq_next = resp_inq_reg;
      case (state_reg)
         ST_IDLE: begin
            if (slot_tick) begin
               if (ps_go) begin
                  state_next    = ST_PS_WIN;
                  win_cnt_next  = '0;
                  win_start[PS] = 1'b1;
               end else if (is_go) begin
                  state_next    = ST_IS_WIN;
                  win_cnt_next  = '0;
                  win_start[IS] = 1'b1;
               end
            end
         end
         ST_PS_WIN, ST_IS_WIN: begin
            // cancel of the running type outranks a same-cycle hit
            if (active_cancel) begin
               state_next = ST_IDLE;
            end else if (rx_hit_p) begin
               state_next    = ST_RESP;
               resp_enter    = 1'b1;
               resp_inq_next = (state_reg == ST_IS_WIN);
            end else if (slot_tick) begin
               if (conn_busy) begin
                  state_next = ST_IDLE;
               end else if (win_end) begin
                  // re-arbitrate at the boundary: no idle slot in between
                  if (ps_go) begin
                     state_next    = ST_PS_WIN;
                     win_cnt_next  = '0;
                     win_start[PS] = 1'b1;
                  end else if (is_go) begin
                     state_next    = ST_IS_WIN;
                     win_cnt_next  = '0;
                     win_start[IS] = 1'b1;
                  end else begin
                     state_next = ST_IDLE;
                  end
               end else begin
                  win_cnt_next = win_cnt_reg + 1'b1;
               end
            end
         end
         ST_RESP: begin
            if (resp_done_p) begin
               state_next    = ST_IDLE;
               resp_inq_next = 1'b0;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // State register and registered start/response pulses
   always_ff @(posedge clk_6M) begin
      if (!rstz) begin
         state_reg    <= ST_IDLE;
         win_cnt_reg  <= '0;
         resp_inq_reg <= 1'b0;
         ps_start_reg <= 1'b0;
         is_start_reg <= 1'b0;
         resp_p_reg   <= 1'b0;
      end else begin
         state_reg    <= state_next;
         win_cnt_reg  <= win_cnt_next;
         resp_inq_reg <= resp_inq_next;
         ps_start_reg <= win_start[PS];
         is_start_reg <= win_start[IS];
         resp_p_reg   <= resp_enter;
      end
   end

`ifdef SCAN_INTERLACE_EN
   logic ilace_reg;

   // Latch the interlace request of the window being started
   always_ff @(posedge clk_6M) begin
      if (!rstz)
         ilace_reg <= 1'b0;
      else if (win_start[PS])
         ilace_reg <= regi_psinterlace;
      else if (win_start[IS])
         ilace_reg <= regi_isinterlace;
   end

   assign ilace_act       = ilace_reg;
   assign interlace_phase = ilace_reg
                            & ((state_reg == ST_PS_WIN) || (state_reg == ST_IS_WIN))
                            & (win_cnt_reg >= win_base);
`else
   logic unused_interlace;

   assign unused_interlace = regi_psinterlace ^ regi_isinterlace;
   assign ilace_act        = 1'b0;
   assign interlace_phase  = 1'b0;
`endif

   assign scan_state      = state_reg;
   assign pagescan_en     = (state_reg == ST_PS_WIN);
   assign inquiryscan_en  = (state_reg == ST_IS_WIN);
   assign ps_start_p      = ps_start_reg;
   assign is_start_p      = is_start_reg;
   assign scan_resp_p     = resp_p_reg;
   assign resp_is_inquiry = resp_inq_reg;

endmodule

// File: tb/tb_lc_scan_scheduler.sv
// Testbench for lc_scan_scheduler (SLOT_CLKS = 4).
// Window starts, window ends and RESP entries are scoreboard events.
// Each expected event (kind, edge number since reset release) is queued
// when the stimulus is driven, then popped and compared by the monitor.
module tb_lc_scan_scheduler;

   localparam int SLOT = 4;
   localparam int W    = 16;

   localparam int K_F_PS = 1;   // pagescan_en fell
   localparam int K_F_IS = 2;   // inquiryscan_en fell
   localparam int K_S_PS = 3;   // ps_start_p seen
   localparam int K_S_IS = 4;   // is_start_p seen
   localparam int K_RESP = 5;   // scan_resp_p seen

   localparam logic [5:0] M_PS_EN  = 6'b000001;
   localparam logic [5:0] M_PS_CAN = 6'b000010;
   localparam logic [5:0] M_IS_EN  = 6'b000100;
   localparam logic [5:0] M_IS_CAN = 6'b001000;
   localparam logic [5:0] M_HIT    = 6'b010000;
   localparam logic [5:0] M_DONE   = 6'b100000;

`ifdef SCAN_INTERLACE_EN
   localparam int ILACE = 1;
`else
   localparam int ILACE = 0;
`endif

   logic         clk_6M = 1'b0;
   logic         rstz = 1'b0;
   logic         ps_en = 1'b0, ps_can = 1'b0, is_en = 1'b0, is_can = 1'b0;
   logic [W-1:0] tps_int = '0, tps_win = '0, tis_int = '0, tis_win = '0;
   logic         psil = 1'b0, isil = 1'b0;
   logic         conn_busy = 1'b0, rx_hit_p = 1'b0, resp_done_p = 1'b0;
   logic         slot_p, pagescan_en, inquiryscan_en, ps_start_p, is_start_p;
   logic         scan_resp_p, resp_is_inquiry, interlace_phase;
   logic [1:0]   scan_state;

   typedef struct {
      int kind;
      int cyc;
   } sb_item_t;

   sb_item_t sb_q[$];
   int       ecount = 0;
   int       n_pass = 0;
   int       n_total = 0;
   logic     ps_prev = 1'b0, is_prev = 1'b0;

   lc_scan_scheduler #(.SLOT_CLKS(SLOT), .CNT_W(W)) dut (
      .clk_6M                         (clk_6M),
      .rstz                           (rstz),
      .regi_PageScanEnable_oneshot    (ps_en),
      .regi_PageScanCancel_oneshot    (ps_can),
      .regi_InquiryScanEnable_oneshot (is_en),
      .regi_InquiryScanCancel_oneshot (is_can),
      .regi_Tpsinterval               (tps_int),
      .regi_Tpswindow                 (tps_win),
      .regi_Tisinterval               (tis_int),
      .regi_Tiswindow                 (tis_win),
      .regi_psinterlace               (psil),
      .regi_isinterlace               (isil),
      .conn_busy                      (conn_busy),
      .rx_hit_p                       (rx_hit_p),
      .resp_done_p                    (resp_done_p),
      .slot_p                         (slot_p),
      .pagescan_en                    (pagescan_en),
      .inquiryscan_en                 (inquiryscan_en),
      .ps_start_p                     (ps_start_p),
      .is_start_p                     (is_start_p),
      .scan_resp_p                    (scan_resp_p),
      .resp_is_inquiry                (resp_is_inquiry),
      .interlace_phase                (interlace_phase),
      .scan_state                     (scan_state)
   );

   always #5 clk_6M = ~clk_6M;

   // edges since reset release
   always @(posedge clk_6M) begin
      if (!rstz) ecount <= 0;
      else       ecount <= ecount + 1;
   end

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_total++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, obs, exp, ecount);
   endtask

   task automatic expect_ev(input int kind, input int cyc);
      sb_item_t it;
      it.kind = kind;
      it.cyc  = cyc;
      sb_q.push_back(it);
   endtask

   task automatic sb_event(input int kind);
      sb_item_t it;
      if (sb_q.size() == 0) begin
         check_eq("sb_unexpected_event", kind, 0);
      end else begin
         it = sb_q.pop_front();
         check_eq("sb_kind", kind, it.kind);
         check_eq("sb_edge", ecount, it.cyc);
         $display("event kind=%0d edge=%0d (expected kind=%0d edge=%0d)",
                  kind, ecount, it.kind, it.cyc);
      end
   endtask

   // Monitor: slot timing, exclusivity and event detection
   always @(negedge clk_6M) begin
      if (!rstz) begin
         ps_prev = 1'b0;
         is_prev = 1'b0;
      end else begin
         check_eq("slot_p", int'(slot_p), ((ecount % SLOT) == SLOT - 1) ? 1 : 0);
         check_eq("excl", int'(pagescan_en & inquiryscan_en), 0);
         if (ps_prev && !pagescan_en)    sb_event(K_F_PS);
         if (is_prev && !inquiryscan_en) sb_event(K_F_IS);
         if (ps_start_p)  sb_event(K_S_PS);
         if (is_start_p)  sb_event(K_S_IS);
         if (scan_resp_p) sb_event(K_RESP);
         ps_prev = pagescan_en;
         is_prev = inquiryscan_en;
      end
   end

   task automatic do_reset();
      @(negedge clk_6M);
      rstz = 1'b0;
      ps_en = 1'b0; ps_can = 1'b0; is_en = 1'b0; is_can = 1'b0;
      conn_busy = 1'b0; rx_hit_p = 1'b0; resp_done_p = 1'b0;
      psil = 1'b0; isil = 1'b0;
      repeat (3) @(negedge clk_6M);
      rstz = 1'b1;
   endtask

   task automatic wait_to(input int e);
      while (ecount < e) @(negedge clk_6M);
   endtask

   task automatic pulse(input logic [5:0] m);
      ps_en = m[0]; ps_can = m[1]; is_en = m[2]; is_can = m[3];
      rx_hit_p = m[4]; resp_done_p = m[5];
      @(negedge clk_6M);
      ps_en = 1'b0; ps_can = 1'b0; is_en = 1'b0; is_can = 1'b0;
      rx_hit_p = 1'b0; resp_done_p = 1'b0;
   endtask

   task automatic set_regs(input int pi, input int pw, input int ii, input int iw);
      tps_int = W'(pi); tps_win = W'(pw); tis_int = W'(ii); tis_win = W'(iw);
   endtask

   task automatic end_scenario(input string tag);
      check_eq(tag, sb_q.size(), 0);
      sb_q.delete();
   endtask

   function automatic int all_outs();
      return int'({slot_p, pagescan_en, inquiryscan_en, ps_start_p, is_start_p,
                   scan_resp_p, resp_is_inquiry, interlace_phase, scan_state});
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // A: periodic page scan 8/2, rx_hit outside window ignored, cancel
      set_regs(8, 2, 8, 3);
      do_reset();
      check_eq("A_reset_outputs", all_outs(), 0);
      expect_ev(K_S_PS, 4);  expect_ev(K_F_PS, 12);
      expect_ev(K_S_PS, 36); expect_ev(K_F_PS, 44);
      expect_ev(K_S_PS, 68); expect_ev(K_F_PS, 76);
      wait_to(1); pulse(M_PS_EN);
      wait_to(3);  check_eq("A_pre_window_en", int'(pagescan_en), 0);
      wait_to(4);  check_eq("A_ps_start", int'(ps_start_p), 1);
      check_eq("A_state_ps", int'(scan_state), 1);
      wait_to(5);  check_eq("A_ps_start_once", int'(ps_start_p), 0);
      wait_to(11); check_eq("A_last_win_clk", int'(pagescan_en), 1);
      wait_to(20); pulse(M_HIT);
      wait_to(22); check_eq("A_hit_ignored", int'(scan_state), 0);
      wait_to(80); pulse(M_PS_CAN);
      wait_to(110);
      end_scenario("A_sb_left");

      // B: PS 8/2 and IS 8/3 together -> back-to-back windows
      set_regs(8, 2, 8, 3);
      do_reset();
      expect_ev(K_S_PS, 4);  expect_ev(K_F_PS, 12); expect_ev(K_S_IS, 12); expect_ev(K_F_IS, 24);
      expect_ev(K_S_PS, 36); expect_ev(K_F_PS, 44); expect_ev(K_S_IS, 44); expect_ev(K_F_IS, 56);
      wait_to(1);  pulse(M_PS_EN | M_IS_EN);
      wait_to(12); check_eq("B_is_en", int'(inquiryscan_en), 1);
      check_eq("B_ps_off", int'(pagescan_en), 0);
      wait_to(23); check_eq("B_is_last_clk", int'(inquiryscan_en), 1);
      wait_to(24); check_eq("B_idle_after_is", int'(scan_state), 0);
      wait_to(60); pulse(M_PS_CAN | M_IS_CAN);
      wait_to(76);
      end_scenario("B_sb_left");

      // C: hit in IS window -> RESP; done -> pending PS then IS
      set_regs(8, 2, 8, 3);
      do_reset();
      expect_ev(K_S_PS, 4); expect_ev(K_F_PS, 12); expect_ev(K_S_IS, 12);
      wait_to(1);  pulse(M_PS_EN | M_IS_EN);
      expect_ev(K_F_IS, 18); expect_ev(K_RESP, 18);
      wait_to(17); pulse(M_HIT);
      check_eq("C_state_resp", int'(scan_state), 3);
      check_eq("C_resp_p", int'(scan_resp_p), 1);
      check_eq("C_resp_inq", int'(resp_is_inquiry), 1);
      wait_to(19); check_eq("C_resp_p_once", int'(scan_resp_p), 0);
      check_eq("C_resp_inq_held", int'(resp_is_inquiry), 1);
      wait_to(25); conn_busy = 1'b1;
      wait_to(30); conn_busy = 1'b0;
      wait_to(36); check_eq("C_resp_holds", int'(scan_state), 3);
      expect_ev(K_S_PS, 40); expect_ev(K_F_PS, 48); expect_ev(K_S_IS, 48); expect_ev(K_F_IS, 60);
      wait_to(38); pulse(M_DONE);
      check_eq("C_idle_after_done", int'(scan_state), 0);
      check_eq("C_resp_inq_clr", int'(resp_is_inquiry), 0);
      wait_to(62);
      end_scenario("C_sb_left");

      // D: conn_busy ends a PS window and defers the next one
      set_regs(8, 2, 8, 3);
      do_reset();
      expect_ev(K_S_PS, 4); expect_ev(K_F_PS, 8);
      wait_to(1); pulse(M_PS_EN);
      wait_to(5); conn_busy = 1'b1;
      wait_to(7); check_eq("D_busy_waits_slot", int'(scan_state), 1);
      wait_to(8); check_eq("D_busy_idle", int'(scan_state), 0);
      wait_to(40); check_eq("D_no_win_busy", int'(pagescan_en), 0);
      expect_ev(K_S_PS, 48); expect_ev(K_F_PS, 56);
      wait_to(45); conn_busy = 1'b0;
      wait_to(66);
      end_scenario("D_sb_left");

      // E: window 8 >= interval 4 -> continuous scan; cancel; enable+cancel
      set_regs(4, 8, 8, 3);
      do_reset();
      expect_ev(K_S_PS, 4); expect_ev(K_S_PS, 36); expect_ev(K_S_PS, 68);
      wait_to(1); pulse(M_PS_EN);
      wait_to(4);
      while (ecount <= 80) begin
         check_eq("E_ps_continuous", int'(pagescan_en), 1);
         @(negedge clk_6M);
      end
      expect_ev(K_F_PS, 82);
      pulse(M_PS_CAN);
      check_eq("E_cancel_drop", int'(pagescan_en), 0);
      check_eq("E_cancel_idle", int'(scan_state), 0);
      wait_to(90); pulse(M_PS_EN | M_PS_CAN);
      wait_to(120); check_eq("E_en_cancel_low", int'(pagescan_en), 0);
      end_scenario("E_sb_left");

      // F: interlace request on PS 16/2
      set_regs(16, 2, 8, 3);
      do_reset();
      psil = 1'b1;
      expect_ev(K_S_PS, 4); expect_ev(K_F_PS, (ILACE != 0) ? 20 : 12);
      wait_to(1);  pulse(M_PS_EN);
      wait_to(5);  check_eq("F_phase_first", int'(interlace_phase), 0);
      wait_to(11); check_eq("F_phase_slot1", int'(interlace_phase), 0);
      wait_to(12); check_eq("F_phase_second", int'(interlace_phase), ILACE);
      wait_to(19); check_eq("F_phase_end", int'(interlace_phase), ILACE);
      check_eq("F_win_len", int'(pagescan_en), ILACE);
      wait_to(30);
      psil = 1'b0;
      end_scenario("F_sb_left");

      // G: reset mid-window clears every output on the next edge
      set_regs(8, 2, 8, 3);
      do_reset();
      expect_ev(K_S_PS, 4);
      wait_to(1); pulse(M_PS_EN);
      wait_to(6); check_eq("G_in_window", int'(pagescan_en), 1);
      rstz = 1'b0;
      @(negedge clk_6M);
      check_eq("G_reset_outputs", all_outs(), 0);
      end_scenario("G_sb_left");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
